// File: rtl/alarm_editor.sv
// Alarm time editor: debounced mode/inc/dec buttons drive an hours/minutes edit FSM.
// Defining ALARM_EDITOR_TIMEOUT_EN adds an idle timeout that abandons an unfinished edit.
module alarm_editor #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic       set_alarm,
  output logic [5:0] set_hours,
  output logic [6:0] set_minutes,
  output logic [5:0] edit_hours,
  output logic [6:0] edit_minutes,
  output logic [1:0] edit_field
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("alarm_editor: DEBOUNCE_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("alarm_editor: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, COMMIT} state_t;

  // Button vectors are packed as {dec, inc, mode}.
  logic [2:0]      sync1_q, sync1_d;
  logic [2:0]      sync2_q, sync2_d;
  logic [2:0]      deb_q, deb_d;
  logic [2:0]      press_q, press_d;
  logic [DB_W-1:0] cnt_q [3];
  logic [DB_W-1:0] cnt_d [3];

  state_t     state_q, state_d;
  logic       set_alarm_q, set_alarm_d;
  logic [5:0] set_hours_q, set_hours_d;
  logic [6:0] set_minutes_q, set_minutes_d;
  logic [5:0] edit_hours_q, edit_hours_d;
  logic [6:0] edit_minutes_q, edit_minutes_d;
  logic [1:0] edit_field_q, edit_field_d;

  logic mode_ev, inc_ev, dec_ev, any_ev;

`ifdef ALARM_EDITOR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  assign mode_ev = press_q[0];
  assign inc_ev  = press_q[1];
  assign dec_ev  = press_q[2];
  assign any_ev  = |press_q;

  // The counter only runs while the synchronised level disagrees with the accepted one,
  // so any bounce back to the accepted level restarts the qualification window.
  always_comb begin
    sync1_d = {btn_dec, btn_inc, btn_mode};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    press_d = deb_d & ~deb_q;
  end

  always_comb begin
    state_d        = state_q;
    set_alarm_d    = 1'b0;
    set_hours_d    = set_hours_q;
    set_minutes_d  = set_minutes_q;
    edit_hours_d   = edit_hours_q;
    edit_minutes_d = edit_minutes_q;
`ifdef ALARM_EDITOR_TIMEOUT_EN
    to_cnt_d       = '0;
`endif
    unique case (state_q)
      IDLE: begin
        edit_hours_d   = set_hours_q;
        edit_minutes_d = set_minutes_q;
        if (mode_ev) state_d = EDIT_H;
      end
      EDIT_H: begin
        if (mode_ev) begin
          state_d = EDIT_M;
        end else if (inc_ev && !dec_ev) begin
          edit_hours_d = (edit_hours_q == 6'd23) ? 6'd0 : edit_hours_q + 6'd1;
        end else if (dec_ev && !inc_ev) begin
          edit_hours_d = (edit_hours_q == 6'd0) ? 6'd23 : edit_hours_q - 6'd1;
        end
      end
      EDIT_M: begin
        if (mode_ev) begin
          state_d       = COMMIT;
          set_alarm_d   = 1'b1;
          set_hours_d   = edit_hours_q;
          set_minutes_d = edit_minutes_q;
        end else if (inc_ev && !dec_ev) begin
          edit_minutes_d = (edit_minutes_q == 7'd59) ? 7'd0 : edit_minutes_q + 7'd1;
        end else if (dec_ev && !inc_ev) begin
          edit_minutes_d = (edit_minutes_q == 7'd0) ? 7'd59 : edit_minutes_q - 7'd1;
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef ALARM_EDITOR_TIMEOUT_EN
    if ((state_q == EDIT_H || state_q == EDIT_M) && !any_ev) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d        = IDLE;
        edit_hours_d   = set_hours_q;
        edit_minutes_d = set_minutes_q;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
    unique case (state_d)
      EDIT_H:  edit_field_d = 2'b01;
      EDIT_M:  edit_field_d = 2'b10;
      default: edit_field_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      deb_q          <= '0;
      press_q        <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      state_q        <= IDLE;
      set_alarm_q    <= 1'b0;
      set_hours_q    <= 6'd6;
      set_minutes_q  <= 7'd0;
      edit_hours_q   <= 6'd6;
      edit_minutes_q <= 7'd0;
      edit_field_q   <= 2'b00;
`ifdef ALARM_EDITOR_TIMEOUT_EN
      to_cnt_q       <= '0;
`endif
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      deb_q          <= deb_d;
      press_q        <= press_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      state_q        <= state_d;
      set_alarm_q    <= set_alarm_d;
      set_hours_q    <= set_hours_d;
      set_minutes_q  <= set_minutes_d;
      edit_hours_q   <= edit_hours_d;
      edit_minutes_q <= edit_minutes_d;
      edit_field_q   <= edit_field_d;
`ifdef ALARM_EDITOR_TIMEOUT_EN
      to_cnt_q       <= to_cnt_d;
`endif
    end
  end

  assign set_alarm    = set_alarm_q;
  assign set_hours    = set_hours_q;
  assign set_minutes  = set_minutes_q;
  assign edit_hours   = edit_hours_q;
  assign edit_minutes = edit_minutes_q;
  assign edit_field   = edit_field_q;

endmodule

// File: tb/tb_alarm_editor.sv
// Directed bench for alarm_editor (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50); timeout
// expectations follow whether ALARM_EDITOR_TIMEOUT_EN is defined.
module tb_alarm_editor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic       set_alarm;
  logic [5:0] set_hours;
  logic [6:0] set_minutes;
  logic [5:0] edit_hours;
  logic [6:0] edit_minutes;
  logic [1:0] edit_field;

  int testsRun = 0;
  int testsFailed = 0;
  int pulses = 0;

`ifdef ALARM_EDITOR_TIMEOUT_EN
  localparam int HoldCycles = 40;
  localparam int TimeoutField = 0;
`else
  localparam int HoldCycles = 200;
  localparam int TimeoutField = 1;
`endif

  typedef struct {
    logic [2:0] btns;
    int         reps;
    int         expField;
    int         expEh;
    int         expEm;
    int         expSh;
    int         expSm;
    int         expPulses;
    string      name;
  } vec_t;

  vec_t vecs [15];

  always #5 clk = ~clk;

  alarm_editor #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .btn_dec      (btn_dec),
    .set_alarm    (set_alarm),
    .set_hours    (set_hours),
    .set_minutes  (set_minutes),
    .edit_hours   (edit_hours),
    .edit_minutes (edit_minutes),
    .edit_field   (edit_field)
  );

  always @(negedge clk) if (set_alarm) pulses++;

  task automatic checkVal(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input int fieldExp, input int ehExp,
                             input int emExp, input int shExp, input int smExp,
                             input int pulsesExp);
    checkVal({name, ".edit_field"}, int'(edit_field), fieldExp);
    checkVal({name, ".edit_hours"}, int'(edit_hours), ehExp);
    checkVal({name, ".edit_minutes"}, int'(edit_minutes), emExp);
    checkVal({name, ".set_hours"}, int'(set_hours), shExp);
    checkVal({name, ".set_minutes"}, int'(set_minutes), smExp);
    checkVal({name, ".set_alarm_pulses"}, pulses, pulsesExp);
    checkVal({name, ".set_alarm"}, int'(set_alarm), 0);
  endtask

  // Press the buttons in btns ({dec,inc,mode}) together, hold, release and let release settle.
  task automatic applyStimulus(input logic [2:0] btns, input int hold);
    @(posedge clk); #1;
    {btn_dec, btn_inc, btn_mode} = btns;
    repeat (hold) @(posedge clk);
    #1;
    {btn_dec, btn_inc, btn_mode} = 3'b000;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{3'b001, 1, 1,  6,  0, 6,  0, 0, "enter_hours"};
    vecs[1]  = '{3'b010, 1, 1,  7,  0, 6,  0, 0, "inc_hours_1"};
    vecs[2]  = '{3'b010, 1, 1,  8,  0, 6,  0, 0, "inc_hours_2"};
    vecs[3]  = '{3'b001, 1, 2,  8,  0, 6,  0, 0, "enter_minutes"};
    vecs[4]  = '{3'b100, 1, 2,  8, 59, 6,  0, 0, "dec_minutes_wrap"};
    vecs[5]  = '{3'b001, 1, 0,  8, 59, 8, 59, 1, "commit_8_59"};
    vecs[6]  = '{3'b010, 1, 0,  8, 59, 8, 59, 0, "inc_in_idle"};
    vecs[7]  = '{3'b001, 1, 1,  8, 59, 8, 59, 0, "reenter_hours"};
    vecs[8]  = '{3'b110, 1, 1,  8, 59, 8, 59, 0, "inc_dec_together"};
    vecs[9]  = '{3'b100, 9, 1, 23, 59, 8, 59, 0, "dec_hours_to_23"};
    vecs[10] = '{3'b010, 1, 1,  0, 59, 8, 59, 0, "inc_hours_wrap"};
    vecs[11] = '{3'b011, 1, 2,  0, 59, 8, 59, 0, "mode_with_inc"};
    vecs[12] = '{3'b010, 1, 2,  0,  0, 8, 59, 0, "inc_minutes_wrap"};
    vecs[13] = '{3'b100, 1, 2,  0, 59, 8, 59, 0, "dec_minutes_wrap_2"};
    vecs[14] = '{3'b001, 1, 0,  0, 59, 0, 59, 1, "commit_0_59"};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 0, 6, 0, 6, 0, 0);
    rst = 1'b1;

    for (int v = 0; v < 15; v++) begin
      pulses = 0;
      for (int r = 0; r < vecs[v].reps; r++) applyStimulus(vecs[v].btns, 10);
      checkOutput(vecs[v].name, vecs[v].expField, vecs[v].expEh, vecs[v].expEm,
                  vecs[v].expSh, vecs[v].expSm, vecs[v].expPulses);
    end

    pulses = 0;
    applyStimulus(3'b001, 10);
    @(posedge clk); #1;
    btn_inc = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    btn_inc = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("glitch_ignored", 1, 0, 59, 0, 59, 0);
    applyStimulus(3'b010, HoldCycles);
    checkOutput("long_hold_single", 1, 1, 59, 0, 59, 0);

    @(posedge clk); #1;
    btn_mode = 1'b1;
    rst = 1'b0;
    #2;
    checkOutput("reset_mid_edit", 0, 6, 0, 6, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("held_through_reset", 1, 6, 0, 6, 0, 0);
    btn_mode = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    pulseReset();
    pulses = 0;
    applyStimulus(3'b001, 10);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("before_timeout", 1, 6, 0, 6, 0, 0);
    repeat (15) @(posedge clk);
    #1;
    checkOutput("after_timeout", TimeoutField, 6, 0, 6, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
